video_fetch_scheduler: RTL
==========================

# video_fetch_scheduler

Shares one single-port video memory (iCE40 SPRAM class, 1-cycle read latency) between the display line fetcher and a host access port. Driven by the video timing generator's `end_of_line`/`end_of_frame` strobes and `v_visible` level, it prefetches each upcoming visible line into a double-banked line buffer during horizontal blanking. Host accesses are granted in every cycle not used by display fetch. Frame base address and line stride come from configuration inputs latched once per frame.

## Interface
- `ADDR_W`, 16: video memory word address width.
- `DATA_W`, 16: memory and line buffer word width.
- `FETCH_WORDS`, 80: words fetched per visible line; range 1 .. 2^`LB_ADDR_W`.
- `LB_ADDR_W`, 7: line buffer address width per bank.

- `clk` in 1: video pixel clock, the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `end_of_line_i` in 1: 1-cycle strobe from timing.
- `end_of_frame_i` in 1: 1-cycle strobe, coincident with the last `end_of_line_i` of a frame.
- `v_visible_i` in 1: the line starting at this strobe is visible.
- `cfg_base_i` in `ADDR_W`: frame start address.
- `cfg_stride_i` in `ADDR_W`: per-line address increment.
- `host_req_i` in 1: host request; held until ack.
- `host_we_i` in 1: 1 = write, 0 = read.
- `host_addr_i` in `ADDR_W`: host address.
- `host_wr_data_i` in `DATA_W`: host write data.
- `host_ack_o` out 1: request issued this cycle.
- `host_rd_valid_o` out 1: host read data valid.
- `host_rd_data_o` out `DATA_W`: host read data.
- `mem_addr_o` out `ADDR_W`: memory address.
- `mem_we_o` out 1: memory write enable.
- `mem_wr_data_o` out `DATA_W`: memory write data.
- `mem_rd_data_i` in `DATA_W`: read data for the access issued in the previous cycle.
- `lb_we_o` out 1: line buffer write enable.
- `lb_bank_o` out 1: line buffer bank being written.
- `lb_addr_o` out `LB_ADDR_W`: line buffer word address.
- `lb_data_o` out `DATA_W`: line buffer write data.
- `disp_bank_o` out 1: bank the display reads for the current line.
- `fetch_overrun_o` out 1: sticky flag, set when a fetch is aborted.

## Operation
- **Reset values:** state IDLE; every output 0; `base_q`, `stride_q`, `line_addr_q` and `word_cnt` = 0.
- **States:** IDLE and FETCH.
- **Fetch start:** an `end_of_line_i` strobe with `v_visible_i` = 1 starts a fetch.
  - Start address = `cfg_base_i` if `end_of_frame_i`, else `line_addr_q + stride_q`, computed mod 2^`ADDR_W`.
  - On `end_of_frame_i`, latch `base_q` and `stride_q` from the config inputs. Config changes mid-frame are ignored.
  - `line_addr_q` takes the start address.
  - Write bank = `~disp_bank_o`.
  - `word_cnt` = 0; go to FETCH.
- **Strobe with `v_visible_i` = 0:** no fetch; `line_addr_q` is unchanged.
- **Bank swap:** on every `end_of_line_i`, `disp_bank_o` takes the bank of the most recently completed fetch.
- **FETCH:**
  - Each cycle, issue a read at `line_addr_q + word_cnt`, with `mem_we_o` = 0.
  - `word_cnt` increments each cycle.
  - After `FETCH_WORDS` reads, return to IDLE.
- **Line buffer write:** one cycle after each fetch read, drive `lb_we_o` = 1, `lb_addr_o` = that read's `word_cnt`, and `lb_data_o` = `mem_rd_data_i`.
- **Host access:**
  - Granted in any cycle where FETCH issues no read.
  - `mem_*` carry the host address, write enable and write data; `host_ack_o` = 1 in that same cycle.
  - Host reads return `host_rd_valid_o` = 1 and `host_rd_data_o` one cycle after the ack.
  - A host write produces no `host_rd_valid_o`.
- **Host back-to-back:** one access per cycle while `host_req_i` stays high and the memory is free.
- **Overrun:** if a fetch-start strobe arrives while in FETCH:
  - Set `fetch_overrun_o`.
  - Abort the current fetch. Its in-flight lb write still completes.
  - Start the new fetch immediately.
  - `fetch_overrun_o` is cleared only by `reset`.
- **Reset mid-fetch:** abort immediately; no further lb writes; no pending `host_rd_valid_o`.

## Timing
- Fetch strobe in cycle T: reads issue in cycles T+1 .. T+`FETCH_WORDS`; lb writes occur in cycles T+2 .. T+`FETCH_WORDS`+1.
- The host is blocked in cycles T+1 .. T+`FETCH_WORDS`.
- A host request pending in cycle T+`FETCH_WORDS`+1 is acked in that cycle.
- Host ack latency is 0 cycles when the memory is idle: `host_ack_o` is asserted combinationally in the first free cycle where `host_req_i` = 1. `mem_*` are driven from that same cycle's decision.
- `host_rd_valid_o` is registered: ack cycle + 1.
- `lb_*` are registered.
- `disp_bank_o` updates on the clock edge ending the strobe cycle.

## Test plan
- **Basic frame:** `FETCH_WORDS`=4, base 0x0100, stride 0x0010, three visible lines with `end_of_frame` on the first strobe.
  - Required: reads at 0x0100–0x0103, then 0x0110–0x0113, then 0x0120–0x0123.
  - `lb_bank_o` alternates 1,0,1; `disp_bank_o` follows one line later.
- **Host during fetch:** host read of 0x0042 requested at T+1 of a fetch.
  - Required: `host_ack_o` at T+5, `mem_addr_o` = 0x0042 at T+5, `host_rd_valid_o` at T+6 with the memory model value.
- **Host write burst while idle:** 3 writes with the request held.
  - Required: 3 consecutive ack cycles, `mem_we_o` = 1 each; no `host_rd_valid_o`.
- **Address wrap and config latch:** base 0xFFF0, stride 0x0010, `ADDR_W`=16.
  - Required: second line starts at 0x0000.
  - `cfg_stride_i` changed mid-frame has no effect until the next `end_of_frame`.
- **Overrun:** second fetch strobe 2 cycles after the first.
  - Required: `fetch_overrun_o` = 1 and stays set.
  - New fetch starts at cycle +1 from the new base.
  - The aborted fetch produces exactly 2 lb writes.
- **Async reset mid-fetch:** `reset` asserted at T+2.
  - Required: all outputs 0 immediately; no lb writes after deassertion until the next visible strobe.

Source files
------------

// File: rtl/video_fetch_scheduler.sv
// Arbitrates one single-port video memory between the display line prefetcher and a host port.
// Visible lines are fetched into a double-banked line buffer; the host gets every cycle the fetch does not use.
module video_fetch_scheduler #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int FETCH_WORDS = 80,
    parameter int LB_ADDR_W   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 end_of_line_i,
    input  logic                 end_of_frame_i,
    input  logic                 v_visible_i,
    input  logic [ADDR_W-1:0]    cfg_base_i,
    input  logic [ADDR_W-1:0]    cfg_stride_i,
    input  logic                 host_req_i,
    input  logic                 host_we_i,
    input  logic [ADDR_W-1:0]    host_addr_i,
    input  logic [DATA_W-1:0]    host_wr_data_i,
    output logic                 host_ack_o,
    output logic                 host_rd_valid_o,
    output logic [DATA_W-1:0]    host_rd_data_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic                 mem_we_o,
    output logic [DATA_W-1:0]    mem_wr_data_o,
    input  logic [DATA_W-1:0]    mem_rd_data_i,
    output logic                 lb_we_o,
    output logic                 lb_bank_o,
    output logic [LB_ADDR_W-1:0] lb_addr_o,
    output logic [DATA_W-1:0]    lb_data_o,
    output logic                 disp_bank_o,
    output logic                 fetch_overrun_o
);

    localparam int CNT_W = LB_ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FETCH_WORDS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] line_addr_q;
    logic [CNT_W-1:0]  word_cnt;
    logic              wr_bank;
    logic              done_bank;

    logic              fetch_start;
    logic              fetch_rd;
    logic              fetch_last;
    logic              host_grant;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] fetch_addr;

    assign fetch_start = end_of_line_i & v_visible_i;
    assign fetch_rd    = (state == FETCH);
    assign fetch_last  = fetch_rd & (word_cnt == LAST_WORD);
    assign host_grant  = host_req_i & ~fetch_rd & ~reset;
    assign start_addr  = end_of_frame_i ? cfg_base_i : (line_addr_q + stride_q);
    assign fetch_addr  = line_addr_q + ADDR_W'(word_cnt);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a new start strobe always wins, even over the last word of a fetch
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (fetch_start) begin
                    state_next = FETCH;
                end else begin
                    state_next = IDLE;
                end
            end
            FETCH: begin
                if (fetch_start) begin
                    state_next = FETCH;
                end else if (fetch_last) begin
                    state_next = IDLE;
                end else begin
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory port mux: fetch reads own the port, otherwise a pending host request is issued at once
    always_comb begin
        mem_addr_o    = {ADDR_W{1'b0}};
        mem_we_o      = 1'b0;
        mem_wr_data_o = {DATA_W{1'b0}};
        host_ack_o    = 1'b0;
        case (state)
            FETCH: begin
                if (!reset) begin
                    mem_addr_o = fetch_addr;
                end else begin
                    mem_addr_o = {ADDR_W{1'b0}};
                end
            end
            IDLE: begin
                if (host_grant) begin
                    mem_addr_o    = host_addr_i;
                    mem_we_o      = host_we_i;
                    mem_wr_data_o = host_wr_data_i;
                    host_ack_o    = 1'b1;
                end else begin
                    host_ack_o    = 1'b0;
                end
            end
            default: host_ack_o = 1'b0;
        endcase
    end

    // Fetch bookkeeping, bank tracking and registered line-buffer / host-read strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stride_q        <= {ADDR_W{1'b0}};
            line_addr_q     <= {ADDR_W{1'b0}};
            word_cnt        <= {CNT_W{1'b0}};
            wr_bank         <= 1'b0;
            done_bank       <= 1'b0;
            disp_bank_o     <= 1'b0;
            fetch_overrun_o <= 1'b0;
            lb_we_o         <= 1'b0;
            lb_bank_o       <= 1'b0;
            lb_addr_o       <= {LB_ADDR_W{1'b0}};
            host_rd_valid_o <= 1'b0;
        end else begin
            if (end_of_line_i) begin
                disp_bank_o <= done_bank;
            end
            if (end_of_line_i && end_of_frame_i) begin
                stride_q <= cfg_stride_i;
            end
            // The new write bank is the opposite of the bank the display switches to at this edge
            if (fetch_start) begin
                line_addr_q <= start_addr;
                word_cnt    <= {CNT_W{1'b0}};
                wr_bank     <= ~done_bank;
                if (fetch_rd) begin
                    fetch_overrun_o <= 1'b1;
                end
            end else if (fetch_rd) begin
                if (fetch_last) begin
                    word_cnt  <= {CNT_W{1'b0}};
                    done_bank <= wr_bank;
                end else begin
                    word_cnt  <= word_cnt + CNT_W'(1);
                end
            end
            lb_we_o         <= fetch_rd;
            lb_bank_o       <= wr_bank;
            lb_addr_o       <= word_cnt[LB_ADDR_W-1:0];
            host_rd_valid_o <= host_grant & ~host_we_i;
        end
    end

    // Read data arrives from memory in the cycle after issue; route it to whichever requester owns it
    always_comb begin
        if (lb_we_o) begin
            lb_data_o = mem_rd_data_i;
        end else begin
            lb_data_o = {DATA_W{1'b0}};
        end
        if (host_rd_valid_o) begin
            host_rd_data_o = mem_rd_data_i;
        end else begin
            host_rd_data_o = {DATA_W{1'b0}};
        end
    end

endmodule
